radix4_seq_divider: RTL

- Iterative unsigned radix-4 restoring divider, the inverse operation to the radix-4 Booth multiplier.
- Used for the softmax normalisation step: exp(x_i) divided by the sum of exponentials.
- Retires 2 quotient bits per cycle, so N/2 iterations per division.
- Valid/ready handshake on both input and output sides; one division in flight at a time.

---
 rtl/div_pkg.sv | 20 ++
 rtl/radix4_digit_sel.sv | 48 ++++
 rtl/radix4_seq_divider.sv | 151 +++++++++++++++
 3 files changed

// File: rtl/div_pkg.sv
// Shared definitions for the radix-4 sequential divider.
//   div_state_e : controller states (IDLE -> CALC -> DONE -> IDLE)
//   DIGIT_W     : width of one radix-4 quotient digit
//   cnt_w()     : width of the iteration counter for an N-bit divide
package div_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } div_state_e;

  localparam int unsigned DIGIT_W = 2;

  // The counter runs from N/2-1 down to 0.
  function automatic int unsigned cnt_w(input int unsigned n);
    return $clog2(n / 2);
  endfunction

endpackage

// File: rtl/radix4_digit_sel.sv
// Combinational radix-4 digit selection for a restoring divider.
// Picks the largest digit d in {0..3} with d*D <= T and returns T - d*D.
// Ports:
//   t     [N+1:0] shifted partial remainder {R, next two dividend bits}
//   d     [N-1:0] divisor
//   d2    [N:0]   2*divisor
//   d3    [N+1:0] 3*divisor
//   digit [1:0]   selected quotient digit
//   rem   [N-1:0] next partial remainder, always < d so N bits suffice
module radix4_digit_sel
  import div_pkg::*;
#(
  parameter int unsigned N = 16
) (
  input  logic [N+1:0]       t,
  input  logic [N-1:0]       d,
  input  logic [N:0]         d2,
  input  logic [N+1:0]       d3,
  output logic [DIGIT_W-1:0] digit,
  output logic [N-1:0]       rem
);

  logic [N-1:0] sub;

  always_comb begin
    if (t >= d3) begin
      digit = 2'd3;
    end else if (t >= {1'b0, d2}) begin
      digit = 2'd2;
    end else if (t >= {2'b00, d}) begin
      digit = 2'd1;
    end else begin
      digit = 2'd0;
    end
  end

  // The true difference is < d, so working modulo 2^N gives the exact result.
  always_comb begin
    case (digit)
      2'd3:    sub = d3[N-1:0];
      2'd2:    sub = d2[N-1:0];
      2'd1:    sub = d;
      default: sub = '0;
    endcase
    rem = t[N-1:0] - sub;
  end

endmodule

// File: rtl/radix4_seq_divider.sv
// Iterative unsigned radix-4 restoring divider, two quotient bits per cycle.
// One division in flight; valid/ready handshakes on both sides.
// Optional build macro: DIV_ROUND_EN rounds the quotient half-up (saturating)
// on completion; the reported remainder stays the truncated one.
// Ports:
//   clk, rst_n              clock, synchronous active-low reset
//   in_valid / in_ready     operand handshake (dividend, divisor)
//   out_valid / out_ready   result handshake (quotient, remainder, div_by_zero)
module radix4_seq_divider
  import div_pkg::*;
#(
  parameter int unsigned N = 16
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [N-1:0] dividend,
  input  logic [N-1:0] divisor,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [N-1:0] quotient,
  output logic [N-1:0] remainder,
  output logic         div_by_zero
);

  localparam int unsigned CntW = cnt_w(N);
  localparam logic [CntW-1:0] CntInit = CntW'(N / 2 - 1);

  div_state_e state_q, state_d;
  logic [N-1:0]    d_q, d_d;
  logic [N+1:0]    d3_q, d3_d;
  logic [N-1:0]    q_q, q_d;
  // Partial remainder is always < D, so N bits hold it exactly.
  logic [N-1:0]    r_q, r_d;
  logic [CntW-1:0] cnt_q, cnt_d;
  logic [N-1:0]    quotient_q, quotient_d;
  logic [N-1:0]    remainder_q, remainder_d;
  logic            dbz_q, dbz_d;

  logic [N+1:0]       t;
  logic [N:0]         d2;
  logic [DIGIT_W-1:0] digit;
  logic [N-1:0]       rem_next;
  logic [N-1:0]       q_next;
  logic [N-1:0]       q_final;

  assign t      = {2'b00, r_q, q_q[N-1:N-2]} << 0;
  assign d2     = {d_q, 1'b0};
  assign q_next = {q_q[N-3:0], digit};

  radix4_digit_sel #(
    .N (N)
  ) u_digit_sel (
    .t     (t),
    .d     (d_q),
    .d2    (d2),
    .d3    (d3_q),
    .digit (digit),
    .rem   (rem_next)
  );

`ifdef DIV_ROUND_EN
  logic round_up;
  // Half-up: bump when the remainder is at least half the divisor.
  assign round_up = {rem_next, 1'b0} >= {1'b0, d_q};
  assign q_final  = (round_up && !(&q_next)) ? q_next + N'(1) : q_next;
`else
  assign q_final  = q_next;
`endif

  always_comb begin
    state_d     = state_q;
    d_d         = d_q;
    d3_d        = d3_q;
    q_d         = q_q;
    r_d         = r_q;
    cnt_d       = cnt_q;
    quotient_d  = quotient_q;
    remainder_d = remainder_q;
    dbz_d       = dbz_q;
    case (state_q)
      IDLE: begin
        if (in_valid) begin
          if (divisor == '0) begin
            state_d     = DONE;
            quotient_d  = '1;
            remainder_d = dividend;
            dbz_d       = 1'b1;
          end else begin
            state_d = CALC;
            d_d     = divisor;
            d3_d    = {2'b00, divisor} + {1'b0, divisor, 1'b0};
            q_d     = dividend;
            r_d     = '0;
            cnt_d   = CntInit;
          end
        end
      end
      CALC: begin
        q_d = q_next;
        r_d = rem_next;
        if (cnt_q == '0) begin
          state_d     = DONE;
          quotient_d  = q_final;
          remainder_d = rem_next;
          dbz_d       = 1'b0;
        end else begin
          cnt_d = cnt_q - CntW'(1);
        end
      end
      DONE: begin
        if (out_ready) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      d_q         <= '0;
      d3_q        <= '0;
      q_q         <= '0;
      r_q         <= '0;
      cnt_q       <= '0;
      quotient_q  <= '0;
      remainder_q <= '0;
      dbz_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      d_q         <= d_d;
      d3_q        <= d3_d;
      q_q         <= q_d;
      r_q         <= r_d;
      cnt_q       <= cnt_d;
      quotient_q  <= quotient_d;
      remainder_q <= remainder_d;
      dbz_q       <= dbz_d;
    end
  end

  assign in_ready    = (state_q == IDLE);
  assign out_valid   = (state_q == DONE);
  assign quotient    = quotient_q;
  assign remainder   = remainder_q;
  assign div_by_zero = dbz_q;

endmodule
